// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the round-robin hold arbiter.
package arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate the request vector so the slot after
// the last owner sits at bit 0, find the first set bit, then map it back.
module rr_priority_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  pick_o
);

    logic [N_REQ-1:0] rot_s;
    logic [ID_W:0]    base_s;
    logic [ID_W:0]    off_s;
    logic [ID_W+1:0]  sum_s;

    // Rotate, find-first, un-rotate; base can equal N_REQ so the doubled vector covers it.
    always_comb begin
        base_s = {1'b0, last_i} + {{ID_W{1'b0}}, 1'b1};
        rot_s  = N_REQ'({req_i, req_i} >> base_s);
        off_s  = {(ID_W+1){1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = (ID_W+1)'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, base_s} + {1'b0, off_s};
        if (sum_s >= (ID_W+2)'(N_REQ)) begin
            pick_o = ID_W'(sum_s - (ID_W+2)'(N_REQ));
        end else begin
            pick_o = ID_W'(sum_s);
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/arbiter_rr_hold.sv
// Round-robin arbiter with request/grant hold and a turnaround cycle between owners.
// Optional grant revocation after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module arbiter_rr_hold
    import arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state_q,  state_d;
    logic [ID_W-1:0]  last_q,   last_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q,   busy_d;
    logic             pick_valid_s;
    logic [ID_W-1:0]  pick_s;
    logic             owner_req_s;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;
`endif

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_valid_s),
        .pick_o  (pick_s)
    );

    assign owner_req_s = |(req & gnt_q);

    // Next-state logic: grant from IDLE, hold or release (or revoke) from BUSY.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d  = ARB_BUSY;
                    last_d   = pick_s;
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                    gnt_id_d = pick_s;
                    busy_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = {CNT_W{1'b0}};
`endif
                end else begin
                    gnt_d    = {N_REQ{1'b0}};
                    gnt_id_d = {ID_W{1'b0}};
                    busy_d   = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (!owner_req_s) begin
                    state_d  = ARB_IDLE;
                    gnt_d    = {N_REQ{1'b0}};
                    gnt_id_d = {ID_W{1'b0}};
                    busy_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d   = ARB_IDLE;
                    gnt_d     = {N_REQ{1'b0}};
                    gnt_id_d  = {ID_W{1'b0}};
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    gnt_d = gnt_q;
                end
`endif
            end
            default: begin
                state_d  = ARB_IDLE;
                gnt_d    = {N_REQ{1'b0}};
                gnt_id_d = {ID_W{1'b0}};
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; the reset pointer makes requester 0 win first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            last_q   <= ID_W'(N_REQ - 1);
            gnt_q    <= {N_REQ{1'b0}};
            gnt_id_q <= {ID_W{1'b0}};
            busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= {CNT_W{1'b0}};
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// Self-checking bench for arbiter_rr_hold: directed table, corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_arbiter_rr_hold;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model state
    int m_owner;
    int m_last;
    int m_held;
    bit m_to;

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           busy;
        logic           to;
    } vec_t;

    vec_t vecs[$];

    arbiter_rr_hold #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD),
        .ID_W     (IDW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] e_gnt, input logic [IDW-1:0] e_id,
                              input logic e_busy, input logic e_to);
        check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
        check({tag, ".busy"},    32'(busy),    32'(e_busy));
        check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && r[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_last  = m_owner;
                    m_held  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_held >= MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, (m_owner >= 0) ? N'(1 << m_owner) : {N{1'b0}},
                   (m_owner >= 0) ? IDW'(m_owner) : {IDW{1'b0}},
                   m_owner >= 0, m_to);
    endtask

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] g, input logic [IDW-1:0] id,
                       input logic b, input logic t);
        vec_t v;
        v.req = r; v.gnt = g; v.id = id; v.busy = b; v.to = t;
        vecs.push_back(v);
    endtask

    // grant must be one-hot or zero on every cycle out of reset
    always @(negedge clk) begin
        if (rst) check("onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    initial begin
        // rotation through all owners with one idle cycle between grants
        add(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
        add(3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b101, 3'b000, 2'd0, 1'b0, 1'b0);
        add(3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
        add(3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
        add(3'b011, 3'b000, 2'd0, 1'b0, 1'b0);
        add(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
        // lone requester 1 for five cycles (revoked at the fifth edge with timeout)
        add(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        add(3'b010, TO_EN ? 3'b000 : 3'b010, TO_EN ? 2'd0 : 2'd1, !TO_EN, TO_EN);
        add(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        // owner 0 re-requests right after release: 2 wins
        add(3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b101, 3'b001, 2'd0, 1'b1, 1'b0);
        add(3'b100, 3'b000, 2'd0, 1'b0, 1'b0);
        add(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
        add(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

        rst = 1'b0;
        req = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req);
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to);
        end

        // requester set 011 held: revoke after MAX_HOLD cycles when enabled
        for (int i = 0; i < 7; i++) begin
            step(3'b011);
`ifdef ARB_TIMEOUT_EN
            if (i < 4)       check_outs($sformatf("hold%0d", i), 3'b001, 2'd0, 1'b1, 1'b0);
            else if (i == 4) check_outs($sformatf("hold%0d", i), 3'b000, 2'd0, 1'b0, 1'b1);
            else             check_outs($sformatf("hold%0d", i), 3'b010, 2'd1, 1'b1, 1'b0);
`else
            check_outs($sformatf("hold%0d", i), 3'b001, 2'd0, 1'b1, 1'b0);
`endif
        end
        step(3'b000);
        check_outs("hold_rel", 3'b000, 2'd0, 1'b0, 1'b0);

        // asynchronous reset while requester 2 owns the grant
        step(3'b100);
        check_outs("pre_rst", 3'b100, 2'd2, 1'b1, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        check_outs("async_rst", 3'b000, 2'd0, 1'b0, 1'b0);
        req = 3'b111;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(3'b111);
        check_outs("post_rst", 3'b001, 2'd0, 1'b1, 1'b0);

        // randomized traffic, biased to keep requests held for a while
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 7));
            step(r);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
